// File: rtl/bpred_pkg.sv
// Shared types for the branch resolve queue: the stored prediction record,
// default widths and the debug-port select encodings.
package bpred_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_PC_W  = 32;
    localparam int DEF_BIM_W = 12;

    // One in-flight prediction, captured at fetch and consumed at resolve.
    typedef struct packed {
        logic [DEF_PC_W-1:0]  pc4;
        logic                 p_dir;
        logic [DEF_PC_W-1:0]  p_target;
        logic [DEF_BIM_W-1:0] bimodal;
    } bpred_entry_t;

    typedef enum logic [1:0] {
        DBG_COUNT   = 2'd0,
        DBG_HEAD_PC = 2'd1,
        DBG_FLAGS   = 2'd2,
        DBG_STATS   = 2'd3
    } bpred_dbg_sel_e;

endpackage

// File: rtl/bpred_resolve_queue_if.sv
// Fetch/execute/predictor-facing signal bundle of the resolve queue.
// master = the pipeline side driving pushes/resolves, slave = the queue.
interface bpred_resolve_queue_if #(
    parameter int PC_W  = 32,
    parameter int BIM_W = 12
);
    logic             fetch_push;
    logic [PC_W-1:0]  fetch_PC4;
    logic             fetch_p_dir;
    logic [PC_W-1:0]  fetch_p_target;
    logic [BIM_W-1:0] fetch_bimodal;
    logic             soin_bpredictor_stall;
    logic             execute_resolve;
    logic             execute_dir;
    logic [PC_W-1:0]  execute_target;
    logic             execute_flush;
    logic [1:0]       soin_bpredictor_debug_sel;

    logic             resolve_full;
    logic             resolve_empty;
    logic             resolve_underflow;
    logic             execute_bpredictor_update;
    logic [PC_W-1:0]  execute_bpredictor_PC4;
    logic [PC_W-1:0]  execute_bpredictor_target;
    logic             execute_bpredictor_dir;
    logic             execute_bpredictor_miss;
    logic [BIM_W-1:0] execute_bpredictor_bimodal;
    logic [31:0]      resolve_debug;

    modport master (
        output fetch_push, fetch_PC4, fetch_p_dir, fetch_p_target, fetch_bimodal,
               soin_bpredictor_stall, execute_resolve, execute_dir, execute_target,
               execute_flush, soin_bpredictor_debug_sel,
        input  resolve_full, resolve_empty, resolve_underflow,
               execute_bpredictor_update, execute_bpredictor_PC4,
               execute_bpredictor_target, execute_bpredictor_dir,
               execute_bpredictor_miss, execute_bpredictor_bimodal, resolve_debug
    );

    modport slave (
        input  fetch_push, fetch_PC4, fetch_p_dir, fetch_p_target, fetch_bimodal,
               soin_bpredictor_stall, execute_resolve, execute_dir, execute_target,
               execute_flush, soin_bpredictor_debug_sel,
        output resolve_full, resolve_empty, resolve_underflow,
               execute_bpredictor_update, execute_bpredictor_PC4,
               execute_bpredictor_target, execute_bpredictor_dir,
               execute_bpredictor_miss, execute_bpredictor_bimodal, resolve_debug
    );
endinterface

// File: rtl/bpred_resolve_fifo.sv
// Synchronous in-order FIFO of prediction records with push, pop and a
// whole-queue clear. Clear wins over push; a pop in the clear cycle is moot.
// The caller only pushes when there is room (or a pop frees a slot).
module bpred_resolve_fifo
    import bpred_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type ENTRY_T = bpred_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  ENTRY_T                 data_i,
    output ENTRY_T                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ENTRY_T           mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push_i) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (pop_i)  rdPtr_d = rdPtr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wrPtr_q] <= data_i;
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/bpred_resolve_queue.sv
// Branch resolve queue: holds predictions in program order, compares them
// with execute outcomes at resolve and drives the predictor update port one
// cycle later. A misprediction or an external flush empties the queue after
// the head has been consumed.
// Optional: define BPRED_RESOLVE_STATS_EN for saturating update/miss counters
// readable through the debug port.
module bpred_resolve_queue
    import bpred_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int PC_W  = DEF_PC_W,
    parameter int BIM_W = DEF_BIM_W
) (
    input logic                  clk,
    input logic                  reset,
    bpred_resolve_queue_if.slave bus
);
    typedef struct packed {
        logic [PC_W-1:0]  pc4;
        logic             p_dir;
        logic [PC_W-1:0]  p_target;
        logic [BIM_W-1:0] bimodal;
    } entry_t;

    entry_t                 pushEntry;
    entry_t                 headEntry;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [$clog2(DEPTH):0] fifoCount;

    logic popEn, missNow, flushNow, pushEn;

    logic             update_q;
    logic [PC_W-1:0]  pc4_q;
    logic [PC_W-1:0]  target_q;
    logic             dir_q;
    logic             miss_q;
    logic [BIM_W-1:0] bimodal_q;
    logic             underflow_q, underflow_d;
    logic [31:0]      debug;

    assign pushEntry = '{pc4: bus.fetch_PC4, p_dir: bus.fetch_p_dir,
                         p_target: bus.fetch_p_target, bimodal: bus.fetch_bimodal};

    // Resolve decision: pop the head, judge it, and decide whether younger
    // entries are wrong-path (flush) so the same-cycle push must be dropped.
    always_comb begin
        popEn    = bus.execute_resolve & ~fifoEmpty;
        missNow  = popEn & ((headEntry.p_dir != bus.execute_dir) |
                            (bus.execute_dir & headEntry.p_dir &
                             (headEntry.p_target != bus.execute_target)));
        flushNow = bus.execute_flush | missNow;
        pushEn   = bus.fetch_push & ~bus.soin_bpredictor_stall &
                   (~fifoFull | popEn) & ~flushNow;
    end

    bpred_resolve_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pushEn),
        .pop_i   (popEn),
        .clear_i (flushNow),
        .data_i  (pushEntry),
        .head_o  (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Underflow is sticky until reset: any resolve that finds nothing to pop.
    always_comb begin
        underflow_d = underflow_q | (bus.execute_resolve & fifoEmpty);
    end

    // Registered predictor update; payload holds when no update is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            update_q    <= 1'b0;
            pc4_q       <= '0;
            target_q    <= '0;
            dir_q       <= 1'b0;
            miss_q      <= 1'b0;
            bimodal_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            update_q    <= popEn;
            underflow_q <= underflow_d;
            if (popEn) begin
                pc4_q     <= headEntry.pc4;
                bimodal_q <= headEntry.bimodal;
                target_q  <= bus.execute_target;
                dir_q     <= bus.execute_dir;
                miss_q    <= missNow;
            end
        end
    end

`ifdef BPRED_RESOLVE_STATS_EN
    logic [31:0] updCnt_q;
    logic [31:0] missCnt_q;

    // Saturating counts of updates issued and of mispredictions among them.
    always_ff @(posedge clk) begin
        if (reset) begin
            updCnt_q  <= '0;
            missCnt_q <= '0;
        end else if (popEn) begin
            if (updCnt_q != '1)             updCnt_q  <= updCnt_q + 32'd1;
            if (missNow && missCnt_q != '1) missCnt_q <= missCnt_q + 32'd1;
        end
    end
`endif

    // Debug word selection.
    always_comb begin
        debug = '0;
        case (bpred_dbg_sel_e'(bus.soin_bpredictor_debug_sel))
`ifdef BPRED_RESOLVE_STATS_EN
            DBG_COUNT:   debug = {8'(fifoCount), updCnt_q[23:0]};
            DBG_STATS:   debug = missCnt_q;
`else
            DBG_COUNT:   debug = 32'(fifoCount);
            DBG_STATS:   debug = '0;
`endif
            DBG_HEAD_PC: debug = 32'(headEntry.pc4);
            DBG_FLAGS:   debug = {29'b0, underflow_q, fifoFull, fifoEmpty};
            default:     debug = '0;
        endcase
    end

    assign bus.resolve_full               = fifoFull;
    assign bus.resolve_empty              = fifoEmpty;
    assign bus.resolve_underflow          = underflow_q;
    assign bus.execute_bpredictor_update  = update_q;
    assign bus.execute_bpredictor_PC4     = pc4_q;
    assign bus.execute_bpredictor_target  = target_q;
    assign bus.execute_bpredictor_dir     = dir_q;
    assign bus.execute_bpredictor_miss    = miss_q;
    assign bus.execute_bpredictor_bimodal = bimodal_q;
    assign bus.resolve_debug              = debug;

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Self-checking bench for bpred_resolve_queue: a directed vector table,
// hand-written full/underflow/reset/stats sequences, then random traffic,
// all checked against a queue-based reference model.
// Honours BPRED_RESOLVE_STATS_EN the same way as the design.
module tb_bpred_resolve_queue;

    localparam int DEPTH = 8;

    logic clk;
    logic reset;

    bpred_resolve_queue_if #(.PC_W(32), .BIM_W(12)) bus ();

    bpred_resolve_queue #(.DEPTH(DEPTH), .PC_W(32), .BIM_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          push;
        logic [31:0] pc4;
        bit          pdir;
        logic [31:0] ptgt;
        logic [11:0] bim;
        bit          stall;
        bit          res;
        bit          dir;
        logic [31:0] tgt;
        bit          flush;
        bit          eUpd;
        bit          eMiss;
        logic [31:0] ePc4;
        logic [11:0] eBim;
        int          eCount;
    } vec_t;

    typedef struct {
        logic [31:0] pc4;
        bit          pdir;
        logic [31:0] ptgt;
        logic [11:0] bim;
    } mEntry_t;

    // reference model state
    mEntry_t     mq[$];
    bit          mUpd, mDir, mMiss, mUnder;
    logic [31:0] mPc4, mTgt;
    logic [11:0] mBim;
    int          mUpdCnt, mMissCnt;
    int          nDropped;

    int nCompared;
    int nMismatch;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit push, logic [31:0] pc4, bit pdir,
                                logic [31:0] ptgt, logic [11:0] bim, bit stall,
                                bit res, bit dir, logic [31:0] tgt, bit flush,
                                bit eUpd, bit eMiss, logic [31:0] ePc4,
                                logic [11:0] eBim, int eCount);
        vec_t v;
        v.rst = rst; v.push = push; v.pc4 = pc4; v.pdir = pdir; v.ptgt = ptgt;
        v.bim = bim; v.stall = stall; v.res = res; v.dir = dir; v.tgt = tgt;
        v.flush = flush; v.eUpd = eUpd; v.eMiss = eMiss; v.ePc4 = ePc4;
        v.eBim = eBim; v.eCount = eCount;
        return v;
    endfunction

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(vec_t v, logic [1:0] sel);
        reset                         = v.rst;
        bus.fetch_push                = v.push;
        bus.fetch_PC4                 = v.pc4;
        bus.fetch_p_dir               = v.pdir;
        bus.fetch_p_target            = v.ptgt;
        bus.fetch_bimodal             = v.bim;
        bus.soin_bpredictor_stall     = v.stall;
        bus.execute_resolve           = v.res;
        bus.execute_dir               = v.dir;
        bus.execute_target            = v.tgt;
        bus.execute_flush             = v.flush;
        bus.soin_bpredictor_debug_sel = sel;
    endtask

    task automatic idle(logic [1:0] sel);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), sel);
    endtask

    // Behavioural model of one clock edge, from the queue's stated rules.
    task automatic modelStep();
        int      preSize;
        bit      doPop;
        bit      wrong;
        mEntry_t h;
        mEntry_t n;
        preSize = mq.size();
        wrong   = 1'b0;
        if (reset) begin
            mq.delete();
            mUpd = 0; mDir = 0; mMiss = 0; mUnder = 0;
            mPc4 = 0; mTgt = 0; mBim = 0;
            mUpdCnt = 0; mMissCnt = 0;
            return;
        end
        doPop = bus.execute_resolve && preSize > 0;
        if (bus.execute_resolve && preSize == 0) mUnder = 1;
        mUpd = doPop;
        if (doPop) begin
            h = mq.pop_front();
            if (h.pdir != bus.execute_dir)       wrong = 1;
            else if (!h.pdir)                    wrong = 0;
            else                                 wrong = (h.ptgt != bus.execute_target);
            mPc4 = h.pc4; mBim = h.bim;
            mDir = bus.execute_dir; mTgt = bus.execute_target; mMiss = wrong;
            mUpdCnt++;
            if (wrong) mMissCnt++;
        end
        if (bus.execute_flush || wrong) begin
            mq.delete();
        end else if (bus.fetch_push && !bus.soin_bpredictor_stall) begin
            if (preSize < DEPTH || doPop) begin
                n.pc4 = bus.fetch_PC4; n.pdir = bus.fetch_p_dir;
                n.ptgt = bus.fetch_p_target; n.bim = bus.fetch_bimodal;
                mq.push_back(n);
            end else begin
                nDropped++;
            end
        end
    endtask

    function automatic logic [31:0] expDebug();
        logic [31:0] d;
        d = '0;
        case (bus.soin_bpredictor_debug_sel)
`ifdef BPRED_RESOLVE_STATS_EN
            2'd0: d = {8'(mq.size()), 24'(mUpdCnt)};
            2'd3: d = 32'(mMissCnt);
`else
            2'd0: d = 32'(mq.size());
            2'd3: d = '0;
`endif
            2'd1: d = (mq.size() > 0) ? mq[0].pc4 : 32'h0;
            2'd2: d = {29'b0, mUnder, (mq.size() == DEPTH), (mq.size() == 0)};
            default: d = '0;
        endcase
        return d;
    endfunction

    task automatic checkOutput();
        checkVal("update",    32'(bus.execute_bpredictor_update), 32'(mUpd));
        checkVal("pc4",       bus.execute_bpredictor_PC4, mPc4);
        checkVal("target",    bus.execute_bpredictor_target, mTgt);
        checkVal("dir",       32'(bus.execute_bpredictor_dir), 32'(mDir));
        checkVal("miss",      32'(bus.execute_bpredictor_miss), 32'(mMiss));
        checkVal("bimodal",   32'(bus.execute_bpredictor_bimodal), 32'(mBim));
        checkVal("full",      32'(bus.resolve_full), 32'(mq.size() == DEPTH));
        checkVal("empty",     32'(bus.resolve_empty), 32'(mq.size() == 0));
        checkVal("underflow", 32'(bus.resolve_underflow), 32'(mUnder));
        if (bus.soin_bpredictor_debug_sel != 2'd1 || mq.size() > 0)
            checkVal("debug", bus.resolve_debug, expDebug());
    endtask

    // One clock: edge, model update on the same edge, sample 1 ns later.
    task automatic step();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    function automatic logic [31:0] dutCount();
`ifdef BPRED_RESOLVE_STATS_EN
        return 32'(bus.resolve_debug[31:24]);
`else
        return bus.resolve_debug;
`endif
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nCompared = 0;
        nMismatch = 0;
        nDropped  = 0;

        // Directed table; expected values derived by hand from the queue rules.
        //          rst psh pc4       pd ptgt      bim    st rs d  tgt       fl  eU eM ePc4      eBim   cnt
        tbl.push_back(mk(1, 0, 0,        0, 0,        0,     0, 0, 0, 0,        0,  0, 0, 0,        0,     0));
        tbl.push_back(mk(0, 1, 32'd128,  1, 32'h40,   12'd3, 0, 0, 0, 0,        0,  0, 0, 0,        0,     1));
        tbl.push_back(mk(0, 0, 0,        0, 0,        0,     0, 1, 1, 32'h40,   0,  1, 0, 32'd128,  12'd3, 0));
        tbl.push_back(mk(0, 0, 0,        0, 0,        0,     0, 0, 0, 0,        0,  0, 0, 0,        0,     0));
        tbl.push_back(mk(0, 1, 32'h100,  1, 32'h200,  12'd5, 0, 0, 0, 0,        0,  0, 0, 0,        0,     1));
        tbl.push_back(mk(0, 1, 32'h104,  1, 32'h204,  12'd6, 0, 0, 0, 0,        0,  0, 0, 0,        0,     2));
        tbl.push_back(mk(0, 1, 32'h108,  1, 32'h208,  12'd7, 0, 0, 0, 0,        0,  0, 0, 0,        0,     3));
        tbl.push_back(mk(0, 1, 32'h10C,  1, 32'h20C,  12'd8, 0, 1, 0, 32'h0,    0,  1, 1, 32'h100,  12'd5, 0));
        tbl.push_back(mk(0, 0, 0,        0, 0,        0,     0, 0, 0, 0,        0,  0, 0, 0,        0,     0));
        tbl.push_back(mk(0, 1, 32'h20,   1, 32'h40,   12'd1, 0, 0, 0, 0,        0,  0, 0, 0,        0,     1));
        tbl.push_back(mk(0, 0, 0,        0, 0,        0,     0, 1, 1, 32'h80,   0,  1, 1, 32'h20,   12'd1, 0));
        tbl.push_back(mk(0, 1, 32'h24,   0, 32'h40,   12'd2, 0, 0, 0, 0,        0,  0, 0, 0,        0,     1));
        tbl.push_back(mk(0, 0, 0,        0, 0,        0,     0, 1, 0, 32'h80,   0,  1, 0, 32'h24,   12'd2, 0));
        tbl.push_back(mk(0, 1, 32'h30,   0, 32'h0,    12'd4, 1, 0, 0, 0,        0,  0, 0, 0,        0,     0));
        tbl.push_back(mk(0, 1, 32'h30,   0, 32'h0,    12'd4, 0, 0, 0, 0,        0,  0, 0, 0,        0,     1));
        tbl.push_back(mk(0, 1, 32'h34,   0, 32'h0,    12'd9, 0, 0, 0, 0,        0,  0, 0, 0,        0,     2));
        tbl.push_back(mk(0, 0, 0,        0, 0,        0,     0, 1, 0, 32'h0,    1,  1, 0, 32'h30,   12'd4, 0));
        tbl.push_back(mk(0, 1, 32'h38,   0, 32'h0,    12'd1, 0, 0, 0, 0,        1,  0, 0, 0,        0,     0));

        $display("[TB] directed table: %0d vectors", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], 2'd0);
            step();
            checkVal($sformatf("tbl%0d_update", i), 32'(bus.execute_bpredictor_update), 32'(tbl[i].eUpd));
            checkVal($sformatf("tbl%0d_count", i), dutCount(), 32'(tbl[i].eCount));
            if (tbl[i].eUpd) begin
                checkVal($sformatf("tbl%0d_miss", i), 32'(bus.execute_bpredictor_miss), 32'(tbl[i].eMiss));
                checkVal($sformatf("tbl%0d_pc4", i), bus.execute_bpredictor_PC4, tbl[i].ePc4);
                checkVal($sformatf("tbl%0d_bim", i), 32'(bus.execute_bpredictor_bimodal), 32'(tbl[i].eBim));
            end
        end

        // Fill to full, push+pop while full, dropped ninth push, then drain.
        $display("[TB] full / drain sequence");
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2'd2);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mk(0, 1, 32'h1000 + 32'(4 * i), 0, 32'h0, 12'(i), 0, 0, 0, 0, 0,
                             0, 0, 0, 0, 0), 2'd2);
            step();
        end
        checkVal("full_after_fill", 32'(bus.resolve_full), 32'd1);
        applyStimulus(mk(0, 1, 32'h2000, 0, 32'h0, 12'd9, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0), 2'd0);
        step();
        checkVal("full_pushpop_update", 32'(bus.execute_bpredictor_update), 32'd1);
        checkVal("full_pushpop_pc4", bus.execute_bpredictor_PC4, 32'h1000);
        checkVal("full_pushpop_count", dutCount(), 32'd8);
        applyStimulus(mk(0, 1, 32'h3000, 0, 32'h0, 12'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2'd0);
        step();
        checkVal("ninth_push_count", dutCount(), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0), 2'd1);
            step();
        end
        checkVal("drain_last_pc4", bus.execute_bpredictor_PC4, 32'h2000);

        // Resolve while empty sets sticky underflow; reset mid-stream clears all.
        $display("[TB] underflow / reset sequence");
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0), 2'd2);
        step();
        checkVal("underflow_no_update", 32'(bus.execute_bpredictor_update), 32'd0);
        checkVal("underflow_set", 32'(bus.resolve_underflow), 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk(0, 1, 32'h4000 + 32'(4 * i), 1, 32'h40, 12'd2, 0, 0, 0, 0, 0,
                             0, 0, 0, 0, 0), 2'd2);
            step();
        end
        checkVal("underflow_held", 32'(bus.resolve_underflow), 32'd1);
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0), 2'd2);
        step();
        checkVal("reset_empty", 32'(bus.resolve_empty), 32'd1);
        checkVal("reset_update", 32'(bus.execute_bpredictor_update), 32'd0);
        checkVal("reset_underflow", 32'(bus.resolve_underflow), 32'd0);
        idle(2'd2);
        step();
        checkVal("after_reset_update", 32'(bus.execute_bpredictor_update), 32'd0);

        // Ten resolves, the first three mispredicted in direction.
        $display("[TB] statistics sequence");
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2'd0);
        step();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(mk(0, 1, 32'h500 + 32'(4 * i), 1, 32'h40, 12'(i), 0, 0, 0, 0, 0,
                             0, 0, 0, 0, 0), 2'd3);
            step();
            applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, (i >= 3), 32'h40, 0, 0, 0, 0, 0, 0), 2'd3);
            step();
        end
        idle(2'd3);
        step();
`ifdef BPRED_RESOLVE_STATS_EN
        checkVal("stats_misses", bus.resolve_debug, 32'd3);
`else
        checkVal("stats_sel3_zero", bus.resolve_debug, 32'd0);
`endif
        idle(2'd0);
        step();
`ifdef BPRED_RESOLVE_STATS_EN
        checkVal("stats_updates", 32'(bus.resolve_debug[23:0]), 32'd10);
`else
        checkVal("stats_sel0_count", bus.resolve_debug, 32'd0);
`endif

        // Random traffic against the model.
        $display("[TB] random phase");
        for (int c = 0; c < 3000; c++) begin
            vec_t v;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.rst   = ($urandom_range(0, 299) == 0);
            v.push  = ($urandom_range(0, 9) < 6);
            v.pc4   = $urandom & 32'h0000_FFFC;
            v.pdir  = 1'($urandom_range(0, 1));
            v.ptgt  = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80;
            v.bim   = 12'($urandom);
            v.stall = ($urandom_range(0, 9) == 0);
            v.res   = ($urandom_range(0, 9) < 4);
            v.flush = ($urandom_range(0, 49) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                v.dir = mq[0].pdir;
                v.tgt = ($urandom_range(0, 3) != 0) ? mq[0].ptgt : 32'hC0;
            end else begin
                v.dir = 1'($urandom_range(0, 1));
                v.tgt = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80;
            end
            applyStimulus(v, 2'($urandom_range(0, 3)));
            step();
        end

        $display("[TB] note: %0d pushes offered while full were dropped (fetch protocol error)", nDropped);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
